// File: rtl/gray_counter_src.sv
// Up/down Gray-code counter with parallel binary load and terminal-count flag.
// Drives a downstream Gray-to-binary converter; index 0 is the MSB throughout.
module gray_counter_src #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [0:WIDTH-1] din,
  output logic [0:WIDTH-1] g,
  output logic             tc,
  output logic             chg
);

  localparam logic [0:WIDTH-1] ONE  = WIDTH'(1);
  localparam logic [0:WIDTH-1] ONES = '1;
  localparam logic [0:WIDTH-1] ZERO = '0;

  logic [0:WIDTH-1] bin;
  logic [0:WIDTH-1] bin_p0;
  logic [0:WIDTH-1] g_p0;
  logic             tc_p0;
  logic             chg_p0;

  // Binary-to-Gray: g[0]=b[0], g[i]=b[i-1]^b[i]; with index 0 as MSB this is b ^ (b >> 1).
  function automatic logic [0:WIDTH-1] to_gray(input logic [0:WIDTH-1] b);
    to_gray = b ^ (b >> 1);
  endfunction

  // Stage p0: next binary state, its Gray image, and the flags derived from it
  always_comb begin
    bin_p0 = bin;
    chg_p0 = 1'b0;
    if (load) begin
      bin_p0 = din;
      chg_p0 = (to_gray(din) != g);
    end else if (en) begin
      bin_p0 = up ? (bin + ONE) : (bin - ONE);
      chg_p0 = 1'b1;
    end
    g_p0  = to_gray(bin_p0);
    tc_p0 = up ? (bin_p0 == ONES) : (bin_p0 == ZERO);
  end

  // Register stage: bin and g update on the same edge so g never lags bin
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= ZERO;
      g   <= ZERO;
      tc  <= 1'b0;
      chg <= 1'b0;
    end else begin
      bin <= bin_p0;
      g   <= g_p0;
      tc  <= tc_p0;
      chg <= chg_p0;
    end
  end

endmodule
